// File: rtl/i2c_codec_responder.sv
// rtl/i2c_codec_responder.sv - write-only I2C target modelling the audio-codec configuration port
//
// Oversamples SCLK/SDIN on clk, detects START/STOP, matches the 7-bit device
// address, ACKs each accepted byte by pulling SDIN low and captures the
// 3-byte codec write (address, register, data) as a 16-bit configuration word.
//
// Ports:
//   clk        in     system clock, all state on its rising edge
//   reset      in     synchronous active-high reset
//   SCLK       in     I2C clock from the master (asynchronous to clk)
//   SDIN       inout  I2C data; driven only low (ACK), otherwise released
//   word       out    last committed word = {register byte, data byte}
//   reg_addr   out    word[15:9]
//   reg_data   out    word[8:0]
//   word_valid out    1-cycle pulse when a new word is committed
//   busy       out    high from START until STOP
//   err        out    1-cycle pulse when a frame is cut short by STOP or repeated START
`timescale 1ns/1ps

module i2c_codec_responder #(
   parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        SCLK,
   inout  wire         SDIN,
   output logic [15:0] word,
   output logic [6:0]  reg_addr,
   output logic [8:0]  reg_data,
   output logic        word_valid,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_REG,
      S_REG_ACK,
      S_DATA,
      S_DATA_ACK,
      S_IGNORE
   } state_t;

   // [0],[1] synchronise; [2] is the previous synced level for edge detection
   logic [2:0]  scl_sync_q;
   logic [2:0]  sda_sync_q;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] hold_q, hold_d;
   logic [15:0] word_q, word_d;
   logic        pull_q, pull_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic        valid_q, valid_d;

   logic scl_lvl, sda_lvl;
   logic scl_rise, scl_fall, sda_rise, sda_fall;
   logic start_det, stop_det;
   logic in_frame;
   logic rx_state;

   assign scl_lvl  = scl_sync_q[1];
   assign sda_lvl  = sda_sync_q[1];
   assign scl_rise =  scl_sync_q[1] & ~scl_sync_q[2];
   assign scl_fall = ~scl_sync_q[1] &  scl_sync_q[2];
   assign sda_rise =  sda_sync_q[1] & ~sda_sync_q[2];
   assign sda_fall = ~sda_sync_q[1] &  sda_sync_q[2];

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   // Once the address is ACKed an interruption means a lost codec write
   assign in_frame = (state_q == S_REG)  || (state_q == S_REG_ACK) ||
                     (state_q == S_DATA) || (state_q == S_DATA_ACK);

   assign rx_state = (state_q == S_ADDR) || (state_q == S_REG) || (state_q == S_DATA);

   assign SDIN = pull_q ? 1'b0 : 1'bz;

   always_ff @(posedge clk) begin
      if (reset) begin
         // Bus-idle level so no edge is seen straight out of reset
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         shift_q    <= 8'd0;
         hold_q     <= 16'd0;
         word_q     <= 16'd0;
         pull_q     <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[1:0], SCLK};
         sda_sync_q <= {sda_sync_q[1:0], SDIN};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         word_q     <= word_d;
         pull_q     <= pull_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      hold_d  = hold_q;
      word_d  = word_q;
      pull_d  = pull_q;
      busy_d  = busy_q;
      err_d   = 1'b0;
      valid_d = 1'b0;

      if (start_det) begin
         pull_d  = 1'b0;
         cnt_d   = 4'd0;
         state_d = S_ADDR;
         busy_d  = 1'b1;
         err_d   = in_frame;
      end else if (stop_det) begin
         pull_d  = 1'b0;
         cnt_d   = 4'd0;
         state_d = S_IDLE;
         busy_d  = 1'b0;
         err_d   = in_frame;
      end else begin
         // Bits 0..7 shift in on SCL rise; count 8 marks the ACK slot
         if (scl_rise && rx_state && (cnt_q != 4'd8)) begin
            shift_d = {shift_q[6:0], sda_lvl};
            cnt_d   = cnt_q + 4'd1;
         end

         if (scl_fall) begin
            case (state_q)
               S_ADDR: begin
                  if (cnt_q == 4'd8) begin
                     // Read requests (LSB 1) fall through to IGNORE and get a NACK
                     if (shift_q == {SLAVE_ADDR, 1'b0}) begin
                        state_d = S_ADDR_ACK;
                        pull_d  = 1'b1;
                     end else begin
                        state_d = S_IGNORE;
                        cnt_d   = 4'd0;
                     end
                  end
               end
               S_ADDR_ACK: begin
                  state_d = S_REG;
                  pull_d  = 1'b0;
                  cnt_d   = 4'd0;
               end
               S_REG: begin
                  if (cnt_q == 4'd8) begin
                     hold_d[15:8] = shift_q;
                     state_d      = S_REG_ACK;
                     pull_d       = 1'b1;
                  end
               end
               S_REG_ACK: begin
                  state_d = S_DATA;
                  pull_d  = 1'b0;
                  cnt_d   = 4'd0;
               end
               S_DATA: begin
                  if (cnt_q == 4'd8) begin
                     hold_d[7:0] = shift_q;
                     state_d     = S_DATA_ACK;
                     pull_d      = 1'b1;
                  end
               end
               S_DATA_ACK: begin
                  word_d  = hold_q;
                  valid_d = 1'b1;
                  state_d = S_IGNORE;
                  pull_d  = 1'b0;
                  cnt_d   = 4'd0;
               end
               default: ;
            endcase
         end
      end
   end

   assign word       = word_q;
   assign reg_addr   = word_q[15:9];
   assign reg_data   = word_q[8:0];
   assign word_valid = valid_q;
   assign busy       = busy_q;
   assign err        = err_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb/tb_i2c_codec_responder.sv - self-checking bench for i2c_codec_responder
`timescale 1ns/1ps

module tb_i2c_codec_responder;

   localparam int T = 12;   // SCLK half period in clk cycles

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        scl = 1'b1;
   logic        sda_low = 1'b0;
   wire         sdin;
   logic [15:0] word;
   logic [6:0]  reg_addr;
   logic [8:0]  reg_data;
   logic        word_valid;
   logic        busy;
   logic        err;

   assign sdin = sda_low ? 1'b0 : 1'bz;
   pullup (sdin);

   i2c_codec_responder dut (
      .clk        (clk),
      .reset      (reset),
      .SCLK       (scl),
      .SDIN       (sdin),
      .word       (word),
      .reg_addr   (reg_addr),
      .reg_data   (reg_data),
      .word_valid (word_valid),
      .busy       (busy),
      .err        (err)
   );

   always #10 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_valid  = 0;
   int          n_err    = 0;
   logic [15:0] sb_q[$];
   logic [15:0] exp_w;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every committed word must match the oldest expected word
   always @(negedge clk) begin
      if (err) n_err++;
      if (word_valid) begin
         n_valid++;
         if (sb_q.size() == 0) begin
            check("unexpected_word_valid", 32'd1, 32'd0);
         end else begin
            exp_w = sb_q.pop_front();
            check("word", {16'd0, word}, {16'd0, exp_w});
            check("reg_addr", {25'd0, reg_addr}, {25'd0, exp_w[15:9]});
            check("reg_data", {23'd0, reg_data}, {23'd0, exp_w[8:0]});
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_low = 1'b0; wait_clk(T);
      scl = 1'b1;     wait_clk(T);
      sda_low = 1'b1; wait_clk(T);
      scl = 1'b0;     wait_clk(T);
   endtask

   task automatic i2c_stop();
      sda_low = 1'b1; wait_clk(T);
      scl = 1'b1;     wait_clk(T);
      sda_low = 1'b0; wait_clk(T);
   endtask

   // Eight data bits; returns with SCL low and SDA released for the ACK slot
   task automatic send_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sda_low = ~b[i]; wait_clk(T);
         scl = 1'b1;      wait_clk(T);
         scl = 1'b0;      wait_clk(2);
      end
      sda_low = 1'b0;
   endtask

   task automatic ack_slot(output logic ack);
      wait_clk(T);
      scl = 1'b1;
      wait_clk(T / 2);
      ack = sdin;
      wait_clk(T / 2);
      scl = 1'b0;
      wait_clk(2);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      send_bits(b);
      ack_slot(ack);
   endtask

   logic a;
   int   v0, e0;

   initial begin
      // Reset state
      wait_clk(3);
      check("rst_word", {16'd0, word}, 32'd0);
      check("rst_word_valid", {31'd0, word_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_sdin_released", {31'd0, sdin}, 32'd1);
      reset = 1'b0;
      wait_clk(5);

      // Full frame 0x34 0x0E 0x4A
      v0 = n_valid; e0 = n_err;
      sb_q.push_back(16'h0E4A);
      i2c_start();
      check("t1_busy_after_start", {31'd0, busy}, 32'd1);
      write_byte(8'h34, a); check("t1_ack_addr", {31'd0, a}, 32'd0);
      write_byte(8'h0E, a); check("t1_ack_reg",  {31'd0, a}, 32'd0);
      write_byte(8'h4A, a); check("t1_ack_data", {31'd0, a}, 32'd0);
      wait_clk(4);
      check("t1_busy_before_stop", {31'd0, busy}, 32'd1);
      i2c_stop();
      check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
      check("t1_valid_count", n_valid - v0, 32'd1);
      check("t1_err_count", n_err - e0, 32'd0);

      // Wrong address 0x36: NACK everywhere, word kept
      v0 = n_valid; e0 = n_err;
      i2c_start();
      write_byte(8'h36, a); check("t2_nack_addr", {31'd0, a}, 32'd1);
      write_byte(8'h55, a); check("t2_nack_extra", {31'd0, a}, 32'd1);
      check("t2_busy_until_stop", {31'd0, busy}, 32'd1);
      i2c_stop();
      check("t2_busy_after_stop", {31'd0, busy}, 32'd0);
      check("t2_valid_count", n_valid - v0, 32'd0);
      check("t2_err_count", n_err - e0, 32'd0);
      check("t2_word_kept", {16'd0, word}, 32'h0E4A);

      // Read request 0x35: NACK, no err
      v0 = n_valid; e0 = n_err;
      i2c_start();
      write_byte(8'h35, a); check("t3_nack_read", {31'd0, a}, 32'd1);
      i2c_stop();
      check("t3_valid_count", n_valid - v0, 32'd0);
      check("t3_err_count", n_err - e0, 32'd0);

      // Truncated by STOP after the register byte
      v0 = n_valid; e0 = n_err;
      i2c_start();
      write_byte(8'h34, a); check("t4_ack_addr", {31'd0, a}, 32'd0);
      write_byte(8'h12, a); check("t4_ack_reg", {31'd0, a}, 32'd0);
      i2c_stop();
      check("t4_err_count", n_err - e0, 32'd1);
      check("t4_valid_count", n_valid - v0, 32'd0);
      check("t4_word_kept", {16'd0, word}, 32'h0E4A);

      // Repeated START after the register byte, then a full frame
      v0 = n_valid; e0 = n_err;
      i2c_start();
      write_byte(8'h34, a);
      write_byte(8'h20, a);
      sb_q.push_back(16'h0C00);
      i2c_start();
      check("t5_err_on_rstart", n_err - e0, 32'd1);
      write_byte(8'h34, a); check("t5_ack_addr", {31'd0, a}, 32'd0);
      write_byte(8'h0C, a); check("t5_ack_reg",  {31'd0, a}, 32'd0);
      write_byte(8'h00, a); check("t5_ack_data", {31'd0, a}, 32'd0);
      i2c_stop();
      check("t5_err_count", n_err - e0, 32'd1);
      check("t5_valid_count", n_valid - v0, 32'd1);

      // Reset while the REG_ACK pull-down is active
      e0 = n_err;
      i2c_start();
      write_byte(8'h34, a);
      send_bits(8'h1E);
      wait_clk(6);
      check("t6_pull_before_reset", {31'd0, sdin}, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("t6_released_1clk", {31'd0, sdin}, 32'd1);
      wait_clk(2);
      check("t6_rst_word", {16'd0, word}, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_valid", {31'd0, word_valid}, 32'd0);
      check("t6_rst_err", {31'd0, err}, 32'd0);
      scl = 1'b1;
      wait_clk(4);
      reset = 1'b0;
      wait_clk(6);
      check("t6_idle_busy", {31'd0, busy}, 32'd0);
      v0 = n_valid;
      sb_q.push_back(16'h1E00);
      i2c_start();
      write_byte(8'h34, a); check("t6_ack_addr", {31'd0, a}, 32'd0);
      write_byte(8'h1E, a); check("t6_ack_reg",  {31'd0, a}, 32'd0);
      write_byte(8'h00, a); check("t6_ack_data", {31'd0, a}, 32'd0);
      i2c_stop();
      check("t6_valid_count", n_valid - v0, 32'd1);
      check("t6_err_count", n_err - e0, 32'd0);
      check("t6_word_final", {16'd0, word}, 32'h1E00);

      wait_clk(4);
      check("sb_empty", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
